mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//   Round-robin arbiter sharing the single-port register-file memory (write/addr/idata/odata) among
//   NUM_REQ requesters (core load/store unit, loader/DMA, debug). Grants one request at a time,
//   drives the memory port for exactly one access cycle, and returns read data with a one-cycle ack.
//   Sits between the requesters and the memory instance; it is the only driver of the memory port.
// PARAMETERS
//   WIDTH      32  data width; matches the memory word width
//   ADDR_WIDTH 5   memory address width (32 entries)
//   NUM_REQ    4   number of requesters (2..8)
// PORTS
//   clk        in   1                   clock, all state on rising edge
//   rst        in   1                   reset, asynchronous, active-high
//   req        in   NUM_REQ             per-requester request; bit i = requester i
//   req_we     in   NUM_REQ             per-requester write enable (1=write, 0=read)
//   req_addr   in   NUM_REQ*ADDR_WIDTH  packed addresses; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_wdata  in   NUM_REQ*WIDTH       packed write data; requester i at [i*WIDTH +: WIDTH]
//   ack        out  NUM_REQ             one-hot, one-cycle pulse: access of requester i complete
//   rdata      out  WIDTH               read data, valid in the ack cycle of a read
//   busy       out  1                   1 whenever state != IDLE
//   mem_write  out  1                   memory write strobe
//   mem_addr   out  ADDR_WIDTH          memory address
//   mem_idata  out  WIDTH               memory write data
//   mem_odata  in   WIDTH               memory read data (combinational from memory)
// BEHAVIOUR
//   - Reset: state=IDLE, rr pointer=0, grant id=0, ack=0, rdata=0, busy=0, mem_write=0,
//     mem_addr=0, mem_idata=0. mem_write decoded from state, so reset drops it immediately.
//   - FSM IDLE -> ACCESS -> ACK -> IDLE; one access per 3 cycles.
//   - IDLE: if |req, pick winner = first set bit at or after pointer (wrapping); register winner id,
//     its we/addr/wdata; -> ACCESS. If req==0, stay IDLE.
//   - ACCESS: mem_addr/mem_idata = latched values; mem_write=1 iff latched we. Write commits at end
//     of this cycle. For a read, rdata <= mem_odata at end of this cycle. pointer <= winner+1 mod NUM_REQ.
//   - ACK: ack[winner]=1 for this one cycle; rdata holds. -> IDLE unconditionally.
//   - rdata holds its value until the next read's ACCESS; unchanged by writes.
//   - Requester rule: hold req/we/addr/wdata stable from assertion until ack; in the cycle after
//     ack either drop req or keep it high (counts as a new request). Inputs sampled only in IDLE;
//     later changes do not affect the access in flight.
//   - req dropped before ack: access in flight still completes and acks.
//   - Fairness: a continuously requesting requester waits at most NUM_REQ-1 grants.
//   - mem_write=0 in IDLE and ACK; mem_addr/mem_idata hold last latched values.
//   - Reset asserted mid-access: returns to IDLE, no ack issued, write in ACCESS may not commit.
// STRUCTURE
//   - mem_arb_pkg (shared include): state encodings ST_IDLE=2'd0, ST_ACCESS=2'd1, ST_ACK=2'd2;
//     NUM_REQ-wide round-robin helper constants.
//   - Sub-module rr_arbiter #(N): combinational req + pointer -> one-hot grant and binary grant id.
//   - mem_arbiter: FSM, latches, pointer register, memory-port drive, rdata register.
// TESTING
//   1. Reset: rst=1 mid-ACCESS of a write -> next sample busy=0, ack=0, mem_write=0, rdata=0.
//   2. Single write/read: req[1], we=1, addr=5, wdata=32'hDEADBEEF -> mem_write=1 one cycle,
//      ack=4'b0010 two cycles after IDLE sample; then read addr 5 -> rdata=32'hDEADBEEF with ack.
//   3. Round-robin: req=4'b1111 held, re-asserted after each ack -> grant order 0,1,2,3,0.
//   4. Pointer wrap: pointer=3, req=4'b0101 -> grant 0, then 2.
//   5. Mid-flight input change: req[2] read addr 3, change addr to 7 during ACCESS -> entry 3 returned.
//   6. Write/read separation: read ack, then write to other addr -> rdata unchanged until next read.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared constants for the register-file memory arbiter.
// FSM encodings plus a small round-robin wrap helper.
package mem_arb_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_ACK    = 2'd2;

    localparam int MIN_REQ = 2;
    localparam int MAX_REQ = 8;

    // Wraps v into 0..n-1 when v is at most one step past the end.
    function automatic int rr_wrap(input int v, input int n);
        return (v >= n) ? v - n : v;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester bus and memory port of the arbiter.
// slave = arbiter side, master = requesters plus memory.
interface mem_arbiter_if #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_REQ    = 4
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ-1:0]            req_we;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*WIDTH-1:0]      req_wdata;
    logic [NUM_REQ-1:0]            ack;
    logic [WIDTH-1:0]              rdata;
    logic                          busy;
    logic                          mem_write;
    logic [ADDR_WIDTH-1:0]         mem_addr;
    logic [WIDTH-1:0]              mem_idata;
    logic [WIDTH-1:0]              mem_odata;

    modport slave (
        input  req, req_we, req_addr, req_wdata, mem_odata,
        output ack, rdata, busy, mem_write, mem_addr, mem_idata
    );

    modport master (
        output req, req_we, req_addr, req_wdata, mem_odata,
        input  ack, rdata, busy, mem_write, mem_addr, mem_idata
    );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first request at or after
// the pointer, wrapping; one-hot and binary forms of the winner.
module rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] gnt_id_o
);
    logic          found;
    logic [IW-1:0] idx;

    always_comb begin
        found    = 1'b0;
        idx      = '0;
        gnt_o    = '0;
        gnt_id_o = '0;
        for (int i = 0; i < N; i++) begin
            idx = IW'(rr_wrap(int'(ptr_i) + i, N));
            if (!found && req_i[idx]) begin
                found      = 1'b1;
                gnt_id_o   = idx;
                gnt_o      = '0;
                gnt_o[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin owner of the single-port register-file memory.
// One access per IDLE -> ACCESS -> ACK pass; ack pulses in ACK.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_REQ    = 4
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [1:0]            state_q, state_d;
    logic [IW-1:0]         ptr_q, ptr_d;
    logic [IW-1:0]         id_q, id_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0]      wdata_q, wdata_d;
    logic [WIDTH-1:0]      rdata_q, rdata_d;

    logic [NUM_REQ-1:0]    gnt;
    logic [IW-1:0]         gnt_id;

    rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
        .req_i    (bus.req),
        .ptr_i    (ptr_q),
        .gnt_o    (gnt),
        .gnt_id_o (gnt_id)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (|bus.req) begin
                    id_d    = gnt_id;
                    we_d    = |(gnt & bus.req_we);
                    addr_d  = bus.req_addr[gnt_id*ADDR_WIDTH +: ADDR_WIDTH];
                    wdata_d = bus.req_wdata[gnt_id*WIDTH +: WIDTH];
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (!we_q) rdata_d = bus.mem_odata;
                ptr_d   = IW'(rr_wrap(int'(id_q) + 1, NUM_REQ));
                state_d = ST_ACK;
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Strobes decode from state so reset removes them at once.
    assign bus.ack       = (state_q == ST_ACK) ?
                           (NUM_REQ'(1) << id_q) : '0;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.mem_write = (state_q == ST_ACCESS) && we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_idata = wdata_q;
    assign bus.rdata     = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: stimulus queues expected acks,
// a negedge monitor pops and compares grant id and read data.
module tb_mem_arbiter;

    localparam int W  = 32;
    localparam int AW = 5;
    localparam int NR = 4;

    typedef struct {
        int          id;
        logic [31:0] rdata;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks = 0;
    int errors = 0;

    exp_t sb[$];
    logic [W-1:0] mem [32];

    mem_arbiter_if #(.WIDTH(W), .ADDR_WIDTH(AW), .NUM_REQ(NR)) bus ();

    mem_arbiter #(.WIDTH(W), .ADDR_WIDTH(AW), .NUM_REQ(NR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 32; i++) mem[i] <= 32'hA000_0000 + i;
    end

    always @(posedge clk) begin
        if (bus.mem_write) mem[bus.mem_addr] <= bus.mem_idata;
    end

    assign bus.mem_odata = mem[bus.mem_addr];

    function automatic void chk(string name, logic [31:0] act,
                                logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        if (!rst && bus.ack != '0) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack got=%b want=none", bus.ack);
            end else begin
                exp_t e;
                logic [NR-1:0] ea;
                e = sb.pop_front();
                ea = '0;
                ea[e.id] = 1'b1;
                chk("ack_onehot", 32'(bus.ack), 32'(ea));
                chk("ack_rdata", bus.rdata, e.rdata);
            end
        end
    end

    task automatic drive(input int id, input bit we,
                         input logic [AW-1:0] a, input logic [W-1:0] d);
        bus.req[id] = 1'b1;
        bus.req_we[id] = we;
        bus.req_addr[id*AW +: AW] = a;
        bus.req_wdata[id*W +: W] = d;
    endtask

    task automatic push(input int id, input logic [31:0] rd);
        exp_t e;
        e.id = id;
        e.rdata = rd;
        sb.push_back(e);
    endtask

    task automatic wait_ack(input int id, input bit drop);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.ack[id]) begin
                if (drop) bus.req[id] = 1'b0;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL ack_timeout got=none want=ack%0d", id);
        bus.req[id] = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req = '0;
        bus.req_we = '0;
        bus.req_addr = '0;
        bus.req_wdata = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_ack", 32'(bus.ack), 0);
        chk("rst_mwrite", 32'(bus.mem_write), 0);
        chk("rst_rdata", bus.rdata, 0);
        chk("rst_maddr", 32'(bus.mem_addr), 0);

        // reset in the middle of a write access
        drive(3, 1'b1, 5'd9, 32'h1111_1111);
        @(negedge clk);
        chk("pre_rst_mwrite", 32'(bus.mem_write), 1);
        rst = 1'b1;
        bus.req = '0;
        @(negedge clk);
        chk("midrst_busy", 32'(bus.busy), 0);
        chk("midrst_ack", 32'(bus.ack), 0);
        chk("midrst_mwrite", 32'(bus.mem_write), 0);
        chk("midrst_rdata", bus.rdata, 0);
        rst = 1'b0;
        @(negedge clk);

        // round robin with all four held: 0,1,2,3,0
        for (int i = 0; i < 4; i++) drive(i, 1'b0, 5'(20 + i), 0);
        push(0, 32'hA000_0014);
        push(1, 32'hA000_0015);
        push(2, 32'hA000_0016);
        push(3, 32'hA000_0017);
        push(0, 32'hA000_0014);
        wait_ack(0, 1'b0);
        wait_ack(1, 1'b0);
        wait_ack(2, 1'b0);
        wait_ack(3, 1'b0);
        wait_ack(0, 1'b0);
        bus.req = '0;
        @(negedge clk);

        // single write then read back, pointer now 1
        drive(1, 1'b1, 5'd5, 32'hDEAD_BEEF);
        push(1, 32'hA000_0014);
        @(negedge clk);
        chk("wr_mwrite", 32'(bus.mem_write), 1);
        chk("wr_maddr", 32'(bus.mem_addr), 5);
        chk("wr_midata", bus.mem_idata, 32'hDEAD_BEEF);
        chk("wr_busy", 32'(bus.busy), 1);
        wait_ack(1, 1'b1);
        chk("ack_mwrite", 32'(bus.mem_write), 0);
        drive(1, 1'b0, 5'd5, 0);
        push(1, 32'hDEAD_BEEF);
        wait_ack(1, 1'b1);

        // requester 2 writes entry 3, pointer becomes 3
        drive(2, 1'b1, 5'd3, 32'h3333_3333);
        push(2, 32'hDEAD_BEEF);
        wait_ack(2, 1'b1);

        // wrap: pointer 3, req 0101 -> 0 then 2
        drive(0, 1'b0, 5'd0, 0);
        drive(2, 1'b0, 5'd3, 0);
        push(0, 32'hA000_0000);
        push(2, 32'h3333_3333);
        wait_ack(0, 1'b1);
        wait_ack(2, 1'b1);
        @(negedge clk);

        // address changed during ACCESS must not matter
        drive(2, 1'b0, 5'd3, 0);
        push(2, 32'h3333_3333);
        @(negedge clk);
        bus.req_addr[2*AW +: AW] = 5'd7;
        wait_ack(2, 1'b1);

        // a write leaves rdata alone until the next read
        drive(0, 1'b1, 5'd10, 32'h5555_AAAA);
        push(0, 32'h3333_3333);
        wait_ack(0, 1'b1);
        @(negedge clk);
        chk("wr_keeps_rdata", bus.rdata, 32'h3333_3333);
        drive(0, 1'b0, 5'd10, 0);
        push(0, 32'h5555_AAAA);
        wait_ack(0, 1'b1);
        drive(3, 1'b0, 5'd5, 0);
        push(3, 32'hDEAD_BEEF);
        wait_ack(3, 1'b1);

        repeat (4) @(negedge clk);
        chk("idle_busy", 32'(bus.busy), 0);
        chk("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
